// File: rtl/placement_registry_if.sv
// Request/result bus between the setup sequencer and the placement registry.
// The sequencer side is the master; the registry is the slave.
interface placement_registry_if #(
    parameter int X_bits         = 8,
    parameter int Y_bits         = 7,
    parameter int NEST_num       = 2,
    parameter int SUGARPATCH_num = 3
);
    localparam int NC_W = $clog2(NEST_num + 1);
    localparam int PC_W = $clog2(SUGARPATCH_num + 1);

    logic                                    req_valid;
    logic                                    req_kind;
    logic                                    req_commit;
    logic [X_bits-1:0]                       req_x;
    logic [Y_bits-1:0]                       req_y;

    logic                                    busy;
    logic                                    done;
    logic                                    collision;
    logic                                    accepted;
    logic [NC_W-1:0]                         nest_count;
    logic [PC_W-1:0]                         patch_count;
    logic                                    nests_full;
    logic                                    patches_full;
    logic [NEST_num-1:0][X_bits-1:0]         nests_X;
    logic [NEST_num-1:0][Y_bits-1:0]         nests_Y;
    logic [SUGARPATCH_num-1:0][X_bits-1:0]   patches_X;
    logic [SUGARPATCH_num-1:0][Y_bits-1:0]   patches_Y;

    modport master (
        output req_valid, req_kind, req_commit, req_x, req_y,
        input  busy, done, collision, accepted, nest_count, patch_count,
               nests_full, patches_full, nests_X, nests_Y, patches_X, patches_Y
    );

    modport slave (
        input  req_valid, req_kind, req_commit, req_x, req_y,
        output busy, done, collision, accepted, nest_count, patch_count,
               nests_full, patches_full, nests_X, nests_Y, patches_X, patches_Y
    );
endinterface

// File: rtl/placement_registry.sv
// Placement registry: stores accepted nest and sugar-patch centres and answers
// collision queries by scanning stored entries one per cycle (nests first,
// then patches). A committing query stores its candidate when it is clear.
//
// state  | meaning
// IDLE   | waiting for a request
// SCAN   | comparing the candidate against entry idx_q
// RESULT | done pulse; publish result and optionally store the candidate
module placement_registry #(
    parameter int X_bits            = 8,
    parameter int Y_bits            = 7,
    parameter int NEST_num          = 2,
    parameter int SUGARPATCH_num    = 3,
    parameter int NEST_RADIUS       = 5,
    parameter int SUGARPATCH_RADIUS = 3,
    parameter int MIN_SEP           = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 clr,
    placement_registry_if.slave  bus
);
    localparam int NC_W  = $clog2(NEST_num + 1);
    localparam int PC_W  = $clog2(SUGARPATCH_num + 1);
    localparam int IDX_W = $clog2(NEST_num + SUGARPATCH_num + 1);
    localparam int XW1   = X_bits + 1;
    localparam int YW1   = Y_bits + 1;

    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

    state_t                                state_q;
    logic                                  kind_q;
    logic                                  commit_q;
    logic [X_bits-1:0]                     x_q;
    logic [Y_bits-1:0]                     y_q;
    logic [IDX_W-1:0]                      idx_q;
    logic                                  hit_q;
    logic                                  done_q;
    logic                                  collision_q;
    logic                                  accepted_q;
    logic [NC_W-1:0]                       nest_count_q;
    logic [PC_W-1:0]                       patch_count_q;
    logic [NEST_num-1:0][X_bits-1:0]       nests_x_q;
    logic [NEST_num-1:0][Y_bits-1:0]       nests_y_q;
    logic [SUGARPATCH_num-1:0][X_bits-1:0] patches_x_q;
    logic [SUGARPATCH_num-1:0][Y_bits-1:0] patches_y_q;

    logic [IDX_W-1:0]  n_total;
    logic              nests_full;
    logic              patches_full;
    logic              kind_full;
    logic [X_bits-1:0] ent_x;
    logic [Y_bits-1:0] ent_y;
    logic              ent_kind;
    logic signed [X_bits:0] dx;
    logic signed [Y_bits:0] dy;
    logic [X_bits:0]   adx;
    logic [Y_bits:0]   ady;
    logic [X_bits:0]   sep_x;
    logic [Y_bits:0]   sep_y;
    int                sep_i;
    logic              hit;

    assign n_total      = IDX_W'(nest_count_q) + IDX_W'(patch_count_q);
    assign nests_full   = (nest_count_q == NC_W'(NEST_num));
    assign patches_full = (patch_count_q == PC_W'(SUGARPATCH_num));
    assign kind_full    = kind_q ? patches_full : nests_full;

    // Select the entry addressed by idx_q and test it against the candidate box.
    // Indices past the stored nests fall through to the patch slots.
    always_comb begin
        ent_x    = '0;
        ent_y    = '0;
        ent_kind = 1'b0;
        for (int i = 0; i < NEST_num; i++) begin
            if (idx_q == IDX_W'(i)) begin
                ent_x    = nests_x_q[i];
                ent_y    = nests_y_q[i];
                ent_kind = 1'b0;
            end
        end
        for (int j = 0; j < SUGARPATCH_num; j++) begin
            if (idx_q == IDX_W'(nest_count_q) + IDX_W'(j)) begin
                ent_x    = patches_x_q[j];
                ent_y    = patches_y_q[j];
                ent_kind = 1'b1;
            end
        end
        sep_i = (kind_q   ? SUGARPATCH_RADIUS : NEST_RADIUS)
              + (ent_kind ? SUGARPATCH_RADIUS : NEST_RADIUS) + MIN_SEP;
        sep_x = XW1'(sep_i);
        sep_y = YW1'(sep_i);
        // One extra bit keeps the difference exact; no wrap across the field edge.
        dx    = $signed({1'b0, x_q}) - $signed({1'b0, ent_x});
        dy    = $signed({1'b0, y_q}) - $signed({1'b0, ent_y});
        adx   = dx[X_bits] ? $unsigned(-dx) : $unsigned(dx);
        ady   = dy[Y_bits] ? $unsigned(-dy) : $unsigned(dy);
        hit   = (adx < sep_x) && (ady < sep_y);
    end

    // Query FSM, result registers and the registry storage.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            kind_q        <= 1'b0;
            commit_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            idx_q         <= '0;
            hit_q         <= 1'b0;
            done_q        <= 1'b0;
            collision_q   <= 1'b0;
            accepted_q    <= 1'b0;
            nest_count_q  <= '0;
            patch_count_q <= '0;
            nests_x_q     <= '0;
            nests_y_q     <= '0;
            patches_x_q   <= '0;
            patches_y_q   <= '0;
        end else if (clr) begin
            state_q       <= IDLE;
            done_q        <= 1'b0;
            nest_count_q  <= '0;
            patch_count_q <= '0;
            nests_x_q     <= '0;
            nests_y_q     <= '0;
            patches_x_q   <= '0;
            patches_y_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        kind_q      <= bus.req_kind;
                        commit_q    <= bus.req_commit;
                        x_q         <= bus.req_x;
                        y_q         <= bus.req_y;
                        idx_q       <= '0;
                        hit_q       <= 1'b0;
                        collision_q <= 1'b0;
                        accepted_q  <= 1'b0;
                        if (n_total != '0) begin
                            state_q <= SCAN;
                        end else begin
                            state_q <= RESULT;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (hit) begin
                        hit_q   <= 1'b1;
                        state_q <= RESULT;
                        done_q  <= 1'b1;
                    end else if (idx_q == n_total - IDX_W'(1)) begin
                        state_q <= RESULT;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                RESULT: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (kind_full) begin
                        // A full kind reports neither a collision nor an acceptance.
                        collision_q <= 1'b0;
                        accepted_q  <= 1'b0;
                    end else begin
                        collision_q <= hit_q;
                        if (commit_q && !hit_q) begin
                            accepted_q <= 1'b1;
                            if (kind_q) begin
                                for (int j = 0; j < SUGARPATCH_num; j++) begin
                                    if (patch_count_q == PC_W'(j)) begin
                                        patches_x_q[j] <= x_q;
                                        patches_y_q[j] <= y_q;
                                    end
                                end
                                patch_count_q <= patch_count_q + PC_W'(1);
                            end else begin
                                for (int i = 0; i < NEST_num; i++) begin
                                    if (nest_count_q == NC_W'(i)) begin
                                        nests_x_q[i] <= x_q;
                                        nests_y_q[i] <= y_q;
                                    end
                                end
                                nest_count_q <= nest_count_q + NC_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.collision    = collision_q;
    assign bus.accepted     = accepted_q;
    assign bus.nest_count   = nest_count_q;
    assign bus.patch_count  = patch_count_q;
    assign bus.nests_full   = nests_full;
    assign bus.patches_full = patches_full;
    assign bus.nests_X      = nests_x_q;
    assign bus.nests_Y      = nests_y_q;
    assign bus.patches_X    = patches_x_q;
    assign bus.patches_Y    = patches_y_q;
endmodule

// File: doc/placement_registry.md
# placement_registry

Stores the accepted nest and sugar-patch centres during simulation setup and answers collision queries against them. Each query scans the stored entries sequentially, one per cycle. A query can also commit its candidate if it is collision-free. It sits beside the setup sequencer: the sequencer proposes random centres, and this block decides acceptance and publishes the stored coordinates to ant setup and sugar placement.

## Interface
Parameters:
- X_bits, 8, x coordinate width
- Y_bits, 7, y coordinate width
- NEST_num, 2, nest slots
- SUGARPATCH_num, 3, patch slots
- NEST_RADIUS, 5, nest half-extent
- SUGARPATCH_RADIUS, 3, patch half-extent
- MIN_SEP, 2, extra clearance between any two objects

Ports:
- Clk  in  1  the single clock
- Reset_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous registry clear, used to re-seed the simulation
- req_valid  in  1  query request; sampled only while busy=0
- req_kind  in  1  0 = nest, 1 = sugar patch
- req_commit  in  1  1 = store the candidate if clear; 0 = probe only
- req_x  in  X_bits  candidate centre x
- req_y  in  Y_bits  candidate centre y
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse in RESULT
- collision  out  1  query result; registered
- accepted  out  1  candidate stored; registered
- nest_count  out  $clog2(NEST_num+1)  stored nests
- patch_count  out  $clog2(SUGARPATCH_num+1)  stored patches
- nests_full, patches_full  out  1  count equals capacity
- nests_X / nests_Y  out  [NEST_num-1:0][X_bits-1:0] / [Y_bits-1:0]  stored nest centres
- patches_X / patches_Y  out  [SUGARPATCH_num-1:0][X_bits-1:0] / [Y_bits-1:0]  stored patch centres

## Operation
- States: IDLE, SCAN, RESULT.
- IDLE
  - On req_valid: latch kind, commit, x and y; clear collision, accepted and the internal hit flag.
  - Set the scan index to 0.
  - Next state is SCAN if N = nest_count + patch_count > 0, otherwise RESULT.
- SCAN
  - Compares one entry per cycle: index 0..nest_count-1 addresses nests, and the following indices address patches.
  - Separation: sep = r_req + r_entry + MIN_SEP, where r is NEST_RADIUS or SUGARPATCH_RADIUS according to kind.
  - Hit when |dx| < sep AND |dy| < sep (Chebyshev box).
  - Differences are computed at X_bits+1 / Y_bits+1 signed width; there is no wrap-around.
  - On a hit: set the hit flag and go to RESULT (early exit).
  - After the last index with no hit: go to RESULT.
- RESULT
  - done=1; collision ← hit.
  - If commit & ~hit & slot available for the kind: write the entry at index count, increment that count, accepted ← 1.
  - If the kind is full: collision=0, accepted=0, and no write.
  - Then return to IDLE.
- req_valid while busy is ignored and is not queued.
- collision and accepted hold their values until the next request is accepted.
- Counts saturate at capacity; stored entries are never overwritten.
- clr
  - In any state: counts ← 0, state ← IDLE, done suppressed; stored coordinates ← 0.
  - clr in the same cycle as req_valid: clr wins and the request is dropped.
- Reset_n low, asynchronously and mid-operation: state IDLE; every output 0, including coordinate arrays and counts.

## Timing
- Request accepted at edge 0.
- With no hit, entry i is compared in the cycle after edge i; RESULT follows edge N, so done is high in the cycle after edge N.
- A hit on entry i puts done high in the cycle after edge i+1.
- Registry update, the new count and accepted are visible after the edge ending RESULT.
- N=0: done in the cycle after edge 0.
- Back-to-back throughput: a new request can be accepted on the edge ending RESULT+1, i.e. the first IDLE cycle.
- The full flags are combinational from the counts.

## Test plan
All scenarios use the default parameters.
- Empty registry, commit nest (40,30):
  - done in the cycle after the acceptance edge; collision=0, accepted=1.
  - nest_count=1, nests_X[0]=40, nests_Y[0]=30.
- Then commit patch (50,30):
  - sep=10, dx=10 → no hit; done after 1 scan cycle; accepted=1, patch_count=1.
- Then commit patch (49,35):
  - dx=9, dy=5 → hit on entry 0; done after edge 1 (early exit); collision=1, accepted=0, counts unchanged.
- Probe (req_commit=0) at (100,90):
  - done after 2 scan cycles, collision=0, accepted=0, counts unchanged.
- Fill nests with (40,30) and (70,60), then commit nest (10,100):
  - nests_full=1; done with collision=0, accepted=0; nest_count stays 2.
- clr asserted during SCAN:
  - next cycle state IDLE, busy=0, no done pulse, counts 0.
- Reset_n pulsed low mid-SCAN:
  - outputs 0 immediately, without a clock edge.
